spi_slave_gen: RTL and testbench

Parametrised successor to our 8-bit SPI slave. Supports all four SPI modes (CPOL/CPHA), configurable word width and bit order, and back-to-back words within one ss frame. Oversamples the SPI pins in the sys_clk domain and exposes valid/ready streams for RX and TX. Sits between the pads and the register/bus logic; replaces the data_latch/data_rdy scheme.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_slave_gen_if.sv | 39 +++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave_gen.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_slave_gen.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the spi_slave_gen block.
//   state_e      : FSM state encoding (IDLE, ACTIVE)
//   EDGE_LEAD/EDGE_TRAIL : names for the two sclk edges of a bit cell
//   edge_select(): maps CPOL/CPHA onto the sclk polarity used for
//                  sampling mosi and for shifting miso
package spi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam bit EDGE_LEAD  = 1'b0;  // sclk leaving the CPOL level
  localparam bit EDGE_TRAIL = 1'b1;  // sclk returning to the CPOL level

  typedef struct packed {
    logic sample_rise;  // 1: sample on sclk rising edge, 0: falling
    logic shift_rise;   // 1: shift on sclk rising edge, 0: falling
  } edge_sel_t;

  function automatic edge_sel_t edge_select(input bit cpol, input bit cpha);
    edge_sel_t sel;
    bit        lead_rise;
    bit        sample_edge;
    lead_rise       = ~cpol;
    sample_edge     = cpha ? EDGE_TRAIL : EDGE_LEAD;
    sel.sample_rise = (sample_edge == EDGE_LEAD) ? lead_rise : ~lead_rise;
    sel.shift_rise  = ~sel.sample_rise;
    return sel;
  endfunction

endpackage

// File: rtl/spi_slave_gen_if.sv
// Pin and stream bundle of spi_slave_gen.
//   pins   : ss, sclk, mosi (to slave), miso, miso_oe (from slave)
//   TX     : tx_data/tx_valid (to slave), tx_ready (from slave)
//   RX     : rx_data/rx_valid (from slave), rx_ready (to slave)
//   status : overrun, underrun, frame_abort (sticky, from slave),
//            clr_flags (to slave)
interface spi_slave_gen_if #(
  parameter int DATA_W = 8
) ();

  logic              ss;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              underrun;
  logic              frame_abort;
  logic              clr_flags;

  modport slave (
    input  ss, sclk, mosi, tx_data, tx_valid, rx_ready, clr_flags,
    output miso, miso_oe, tx_ready, rx_data, rx_valid,
           overrun, underrun, frame_abort
  );

  modport master (
    output ss, sclk, mosi, tx_data, tx_valid, rx_ready, clr_flags,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid,
           overrun, underrun, frame_abort
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with edge pulses.
//   clk_i   : system clock
//   rst_ni  : synchronous active-low reset (chain loads RST_VAL)
//   d_i     : asynchronous pin
//   level_o : synchronised level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_gen.sv
// Oversampling SPI slave, all four modes, DATA_W-bit words, either bit
// order, back-to-back words within one ss frame.
//   sys_clk_i : sole clock
//   rst_ni    : synchronous active-low reset
//   bus       : spi_slave_gen_if.slave (pins, TX/RX streams, sticky flags)
//
//   state  | meaning
//   IDLE   | ss low; miso_oe low; waiting for ss rising edge
//   ACTIVE | ss high; sampling mosi / shifting miso on sclk edges
module spi_slave_gen
  import spi_pkg::*;
#(
  parameter int              DATA_W      = 8,
  parameter bit              CPOL        = 1'b0,
  parameter bit              CPHA        = 1'b0,
  parameter bit              MSB_FIRST   = 1'b1,
  parameter int              SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE   = '0
) (
  input  logic           sys_clk_i,
  input  logic           rst_ni,
  spi_slave_gen_if.slave bus
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam edge_sel_t        SEL      = edge_select(CPOL, CPHA);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_rise, sclk_fall;
  logic sclk_lvl_unused;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_lvl;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .clk_i   (sys_clk_i),
    .rst_ni  (rst_ni),
    .d_i     (bus.ss),
    .level_o (ss_lvl),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk_i   (sys_clk_i),
    .rst_ni  (rst_ni),
    .d_i     (bus.sclk),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  always_ff @(posedge sys_clk_i) begin
    if (!rst_ni) mosi_sync_q <= '0;
    else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
  end
  assign mosi_lvl = mosi_sync_q[SYNC_STAGES-1];

  // sclk edges only count while the synchronised ss is high
  logic sample_ev, shift_pulse;
  assign sample_ev   = ss_lvl & (SEL.sample_rise ? sclk_rise : sclk_fall);
  assign shift_pulse = ss_lvl & (SEL.shift_rise  ? sclk_rise : sclk_fall);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
  logic              tx_full_q, tx_full_d;
  // The word loaded into tx_shift is only "peeked": the buffer is released
  // (or underrun raised) at the first sample edge of the word, so a frame
  // ending on a word boundary neither consumes the buffer nor flags underrun.
  logic              peek_buf_q, peek_buf_d;
  logic              commit_q, commit_d;
  logic              first_q, first_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              abort_q, abort_d;

  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_load_val;
  logic              tx_out_bit;
  logic [DATA_W-1:0] tx_shifted;

  assign rx_next     = MSB_FIRST ? {rx_shift_q[DATA_W-2:0], mosi_lvl}
                                 : {mosi_lvl, rx_shift_q[DATA_W-1:1]};
  assign tx_load_val = tx_full_q ? tx_buf_q : TX_IDLE;
  assign tx_out_bit  = MSB_FIRST ? tx_shift_q[DATA_W-1] : tx_shift_q[0];
  assign tx_shifted  = MSB_FIRST ? {tx_shift_q[DATA_W-2:0], 1'b0}
                                 : {1'b0, tx_shift_q[DATA_W-1:1]};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    peek_buf_d = peek_buf_q;
    commit_d   = commit_q;
    first_d    = 1'b0;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    abort_d    = abort_q;

    if (bus.tx_valid && !tx_full_q) begin
      tx_buf_d  = bus.tx_data;
      tx_full_d = 1'b1;
    end

    // clear first so that a set event in the same cycle wins
    if (bus.clr_flags) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
      abort_d    = 1'b0;
    end

    if (rx_valid_q && bus.rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        if (ss_rise) begin
          state_d    = ST_ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = tx_load_val;
          peek_buf_d = tx_full_q;
          commit_d   = 1'b1;
          first_d    = ~CPHA;  // CPHA=0 drives bit 0 before any sclk edge
        end
      end
      ST_ACTIVE: begin
        if (ss_fall) begin
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          commit_d   = 1'b0;
          if (bit_cnt_q != '0) abort_d = 1'b1;
        end else begin
          if (first_q || shift_pulse) begin
            miso_d     = tx_out_bit;
            tx_shift_d = tx_shifted;
          end
          if (sample_ev) begin
            rx_shift_d = rx_next;
            if (commit_q) begin
              commit_d = 1'b0;
              if (peek_buf_q) tx_full_d  = 1'b0;
              else            underrun_d = 1'b1;
            end
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              tx_shift_d = tx_load_val;
              peek_buf_d = tx_full_q;
              commit_d   = 1'b1;
              if (!rx_valid_q || bus.rx_ready) begin
                rx_data_d  = rx_next;
                rx_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    miso_oe_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge sys_clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      peek_buf_q <= 1'b0;
      commit_q   <= 1'b0;
      first_q    <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      peek_buf_q <= peek_buf_d;
      commit_q   <= commit_d;
      first_q    <= first_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.tx_ready    = ~tx_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.underrun    = underrun_q;
  assign bus.frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: dut_a is mode 0 / 8 bit / MSB first /
// TX_IDLE=0xFF, dut_b is mode 3 / 16 bit / LSB first. Both share the
// master sclk/mosi; each has its own ss, so the idle one ignores the clock.
`timescale 1ns/1ps
module tb_spi_slave_gen;

  localparam int HALF = 80;  // sclk half period in ns (8 sys_clk cycles)

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic rst_n;
  logic sclk_m, mosi_m;

  spi_slave_gen_if #(.DATA_W(8))  bus_a ();
  spi_slave_gen_if #(.DATA_W(16)) bus_b ();

  assign bus_a.sclk = sclk_m;
  assign bus_a.mosi = mosi_m;
  assign bus_b.sclk = sclk_m;
  assign bus_b.mosi = mosi_m;

  spi_slave_gen #(
    .DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
    .SYNC_STAGES(2), .TX_IDLE(8'hFF)
  ) dut_a (
    .sys_clk_i (sys_clk),
    .rst_ni    (rst_n),
    .bus       (bus_a.slave)
  );

  spi_slave_gen #(
    .DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0),
    .SYNC_STAGES(2), .TX_IDLE(16'h0000)
  ) dut_b (
    .sys_clk_i (sys_clk),
    .rst_ni    (rst_n),
    .bus       (bus_b.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic ss_on(input bit sel_b, input bit cpol);
    sclk_m = cpol;
    #100;
    if (sel_b) bus_b.ss = 1'b1; else bus_a.ss = 1'b1;
    #100;
  endtask

  task automatic ss_off(input bit sel_b);
    #HALF;
    if (sel_b) bus_b.ss = 1'b0; else bus_a.ss = 1'b0;
    #100;
  endtask

  // Clocks n bits of a w-bit word; returns what the slave drove on miso.
  task automatic clock_bits(input bit sel_b, input int w, input int n,
                            input logic [31:0] mo, input bit msbf,
                            input bit cpol, input bit cpha,
                            output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = msbf ? (w - 1 - i) : i;
      if (!cpha) begin
        mosi_m = mo[idx];
        #HALF;
        mi[idx] = sel_b ? bus_b.miso : bus_a.miso;
        sclk_m = ~cpol;
        #HALF;
        sclk_m = cpol;
      end else begin
        sclk_m = ~cpol;
        mosi_m = mo[idx];
        #HALF;
        mi[idx] = sel_b ? bus_b.miso : bus_a.miso;
        sclk_m = cpol;
        #HALF;
      end
    end
  endtask

  task automatic push_a(input logic [7:0] v);
    @(negedge sys_clk);
    bus_a.tx_data  = v;
    bus_a.tx_valid = 1'b1;
    @(negedge sys_clk);
    bus_a.tx_valid = 1'b0;
  endtask

  task automatic push_b(input logic [15:0] v);
    @(negedge sys_clk);
    bus_b.tx_data  = v;
    bus_b.tx_valid = 1'b1;
    @(negedge sys_clk);
    bus_b.tx_valid = 1'b0;
  endtask

  task automatic ack_a();
    @(negedge sys_clk);
    bus_a.rx_ready = 1'b1;
    @(negedge sys_clk);
    bus_a.rx_ready = 1'b0;
  endtask

  task automatic clr_a();
    @(negedge sys_clk);
    bus_a.clr_flags = 1'b1;
    @(negedge sys_clk);
    bus_a.clr_flags = 1'b0;
  endtask

  logic [31:0] mi;

  initial begin
    rst_n = 1'b0;
    sclk_m = 1'b0;
    mosi_m = 1'b0;
    bus_a.ss = 1'b0;  bus_b.ss = 1'b0;
    bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0; bus_a.clr_flags = 1'b0;
    bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0; bus_b.clr_flags = 1'b0;
    cycles(5);

    // reset state
    chk("rst_miso",     bus_a.miso, 0);
    chk("rst_miso_oe",  bus_a.miso_oe, 0);
    chk("rst_tx_ready", bus_a.tx_ready, 1);
    chk("rst_rx_valid", bus_a.rx_valid, 0);
    chk("rst_rx_data",  bus_a.rx_data, 0);
    chk("rst_flags",    {bus_a.overrun, bus_a.underrun, bus_a.frame_abort}, 0);
    chk("rst_b_tx_ready", bus_b.tx_ready, 1);
    chk("rst_b_rx_data",  bus_b.rx_data, 0);
    rst_n = 1'b1;
    cycles(5);

    // mode 0, 0xA5 in, 0x3C out
    push_a(8'h3C);
    chk("t1_tx_ready_full", bus_a.tx_ready, 0);
    ss_on(1'b0, 1'b0);
    chk("t1_miso_oe_on", bus_a.miso_oe, 1);
    clock_bits(1'b0, 8, 8, 32'hA5, 1'b1, 1'b0, 1'b0, mi);
    chk("t1_miso_word", mi, 32'h3C);
    ss_off(1'b0);
    chk("t1_rx_data",  bus_a.rx_data, 32'hA5);
    chk("t1_rx_valid", bus_a.rx_valid, 1);
    chk("t1_underrun", bus_a.underrun, 0);
    chk("t1_overrun",  bus_a.overrun, 0);
    chk("t1_tx_ready", bus_a.tx_ready, 1);
    chk("t1_miso_oe_off", bus_a.miso_oe, 0);
    ack_a();
    cycles(1);
    chk("t1_rx_valid_acked", bus_a.rx_valid, 0);

    // mode 3, 16 bit, LSB first
    push_b(16'h1234);
    ss_on(1'b1, 1'b1);
    clock_bits(1'b1, 16, 16, 32'hBEEF, 1'b0, 1'b1, 1'b1, mi);
    chk("t2_miso_word", mi, 32'h1234);
    ss_off(1'b1);
    chk("t2_rx_data",  bus_b.rx_data, 32'hBEEF);
    chk("t2_rx_valid", bus_b.rx_valid, 1);
    chk("t2_underrun", bus_b.underrun, 0);
    chk("t2_abort",    bus_b.frame_abort, 0);

    // back-to-back words, rx_ready held low
    push_a(8'h81);
    ss_on(1'b0, 1'b0);
    clock_bits(1'b0, 8, 8, 32'h11, 1'b1, 1'b0, 1'b0, mi);
    chk("t3_miso_w0", mi, 32'h81);
    clock_bits(1'b0, 8, 8, 32'h22, 1'b1, 1'b0, 1'b0, mi);
    chk("t3_miso_w1", mi, 32'hFF);
    ss_off(1'b0);
    chk("t3_rx_data",  bus_a.rx_data, 32'h11);
    chk("t3_rx_valid", bus_a.rx_valid, 1);
    chk("t3_overrun",  bus_a.overrun, 1);
    chk("t3_underrun", bus_a.underrun, 1);
    clr_a();
    cycles(1);
    chk("t3_overrun_clr",  bus_a.overrun, 0);
    chk("t3_underrun_clr", bus_a.underrun, 0);
    chk("t3_rx_data_kept", bus_a.rx_data, 32'h11);
    ack_a();

    // empty TX buffer: idle word goes out, late write held for next frame
    ss_on(1'b0, 1'b0);
    push_a(8'h96);
    clock_bits(1'b0, 8, 8, 32'h3C, 1'b1, 1'b0, 1'b0, mi);
    chk("t4_miso_idle", mi, 32'hFF);
    ss_off(1'b0);
    chk("t4_underrun", bus_a.underrun, 1);
    chk("t4_tx_held",  bus_a.tx_ready, 0);
    chk("t4_rx_data",  bus_a.rx_data, 32'h3C);
    ack_a();
    clr_a();
    ss_on(1'b0, 1'b0);
    clock_bits(1'b0, 8, 8, 32'h00, 1'b1, 1'b0, 1'b0, mi);
    chk("t4_miso_held", mi, 32'h96);
    ss_off(1'b0);
    chk("t4_tx_ready",    bus_a.tx_ready, 1);
    chk("t4_underrun_0",  bus_a.underrun, 0);
    chk("t4_rx_data2",    bus_a.rx_data, 32'h00);
    ack_a();

    // ss dropped after 3 bits
    ss_on(1'b0, 1'b0);
    clock_bits(1'b0, 8, 3, 32'hE7, 1'b1, 1'b0, 1'b0, mi);
    ss_off(1'b0);
    chk("t5_rx_valid", bus_a.rx_valid, 0);
    chk("t5_abort",    bus_a.frame_abort, 1);
    chk("t5_bit_cnt",  dut_a.bit_cnt_q, 0);
    clr_a();
    ss_on(1'b0, 1'b0);
    clock_bits(1'b0, 8, 8, 32'h5A, 1'b1, 1'b0, 1'b0, mi);
    ss_off(1'b0);
    chk("t5_rx_data",  bus_a.rx_data, 32'h5A);
    chk("t5_rx_valid2", bus_a.rx_valid, 1);
    chk("t5_abort_0",  bus_a.frame_abort, 0);
    ack_a();
    clr_a();

    // reset mid-word
    ss_on(1'b0, 1'b0);
    clock_bits(1'b0, 8, 3, 32'hC0, 1'b1, 1'b0, 1'b0, mi);
    chk("t6_pre_underrun", bus_a.underrun, 1);
    chk("t6_pre_miso_oe",  bus_a.miso_oe, 1);
    @(negedge sys_clk);
    rst_n = 1'b0;
    @(negedge sys_clk);
    chk("t6_miso",     bus_a.miso, 0);
    chk("t6_miso_oe",  bus_a.miso_oe, 0);
    chk("t6_tx_ready", bus_a.tx_ready, 1);
    chk("t6_rx_valid", bus_a.rx_valid, 0);
    chk("t6_flags",    {bus_a.overrun, bus_a.underrun, bus_a.frame_abort}, 0);
    bus_a.ss = 1'b0;
    sclk_m = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
    push_a(8'h3C);
    ss_on(1'b0, 1'b0);
    clock_bits(1'b0, 8, 8, 32'h69, 1'b1, 1'b0, 1'b0, mi);
    chk("t6_miso_word", mi, 32'h3C);
    ss_off(1'b0);
    chk("t6_rx_data",  bus_a.rx_data, 32'h69);
    chk("t6_rx_valid", bus_a.rx_valid, 1);
    chk("t6_abort",    bus_a.frame_abort, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
